rt_multi_shade_core: RTL

//   Parametrised per-pixel ray-tracing shader, successor to the single-sphere/single-light core.

---
 rtl/rt_multi_shade_core_if.sv | 47 ++++
 rtl/rt_multi_shade_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_multi_shade_core_if.sv
// Bundle of the pixel-scanner handshake, frame-buffer handshake, scene-write
// port and the ray/sphere-intersection (RSI) request/done pair used by
// rt_multi_shade_core.
//   slave  : view taken by the shading core
//   master : view taken by the surrounding system (scanner, writer, RSI unit)
// Packing of the vector fields: field k sits at [k*COORD_W +: COORD_W],
// with x = field 0, y = field 1, z = field 2, r / light intensity = field 3.
interface rt_multi_shade_core_if #(
  parameter int COORD_W = 16,
  parameter int COLOR_W = 4
);
  logic                   PIX_VALID;
  logic                   PIX_READY;
  logic [9:0]             X_in;
  logic [8:0]             Y_in;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [COLOR_W-1:0]     OUTPUT_PIXEL;
  logic                   SCENE_WE;
  logic                   SCENE_SEL;
  logic [3:0]             SCENE_IDX;
  logic [4*COORD_W-1:0]   SCENE_DATA;
  logic                   BUSY;
  logic                   RSI_REQ;
  logic [4*COORD_W-1:0]   RSI_SPHERE;
  logic [3*COORD_W-1:0]   RSI_P0;
  logic [3*COORD_W-1:0]   RSI_P1;
  logic                   RSI_BOUNDED;
  logic [3:0]             RSI_THRESH;
  logic                   RSI_DONE;
  logic                   RSI_COLLIDE;
  logic [3*COORD_W-1:0]   RSI_PNEAR;

  modport slave (
    input  PIX_VALID, X_in, Y_in, OUT_READY, SCENE_WE, SCENE_SEL, SCENE_IDX,
           SCENE_DATA, RSI_DONE, RSI_COLLIDE, RSI_PNEAR,
    output PIX_READY, OUT_VALID, OUTPUT_PIXEL, BUSY, RSI_REQ, RSI_SPHERE,
           RSI_P0, RSI_P1, RSI_BOUNDED, RSI_THRESH
  );

  modport master (
    output PIX_VALID, X_in, Y_in, OUT_READY, SCENE_WE, SCENE_SEL, SCENE_IDX,
           SCENE_DATA, RSI_DONE, RSI_COLLIDE, RSI_PNEAR,
    input  PIX_READY, OUT_VALID, OUTPUT_PIXEL, BUSY, RSI_REQ, RSI_SPHERE,
           RSI_P0, RSI_P1, RSI_BOUNDED, RSI_THRESH
  );
endinterface

// File: rtl/rt_multi_shade_core.sv
// Per-pixel ray-tracing shader. A primary ray from the camera through
// (X,Y,FOCAL) is tested against every populated sphere slot through an
// external RSI unit; the nearest hit point then casts bounded shadow rays to
// every lit light slot. Brightness = AMBIENT + sum of unoccluded light
// intensities, saturating at 2^COLOR_W-1; a miss yields 0.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : rt_multi_shade_core_if.slave (pixel in, pixel out, scene
//                write, RSI request/done)
// Optional feature macro RT_ANIM_EN: accepting pixel (0,0) moves sphere 0
// along x (x+1 below 540, otherwise back to 100) before its primary ray.
module rt_multi_shade_core #(
  parameter int NUM_SPHERES = 4,
  parameter int NUM_LIGHTS  = 2,
  parameter int COORD_W     = 16,
  parameter int COLOR_W     = 4,
  parameter int FOCAL       = 1000,
  parameter int CAM_X       = 320,
  parameter int CAM_Y       = 240,
  parameter int CAM_Z       = 0,
  parameter int SHADOW_THR  = 10,
  parameter int AMBIENT     = 2
) (
  input logic CLK,
  input logic RESET,
  rt_multi_shade_core_if.slave bus
);
  localparam int SW    = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1;
  localparam int LW    = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam int DW    = 2*COORD_W + 2;
  localparam int PW    = 3*COORD_W;
  localparam int EW    = 4*COORD_W;
  localparam int AMB_C = (AMBIENT > (1 << COLOR_W) - 1) ? (1 << COLOR_W) - 1 : AMBIENT;

  typedef enum logic [2:0] {IDLE, P_ISSUE, P_WAIT, P_NEXT, S_ISSUE, S_WAIT, S_NEXT, OUT} state_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Squared distance of a point from the camera.
  function automatic logic [DW-1:0] dist_sq(input logic [PW-1:0] p);
    logic [COORD_W-1:0]   dx, dy, dz;
    logic [2*COORD_W-1:0] sx, sy, sz;
    dx = abs_diff(p[0 +: COORD_W], COORD_W'(CAM_X));
    dy = abs_diff(p[COORD_W +: COORD_W], COORD_W'(CAM_Y));
    dz = abs_diff(p[2*COORD_W +: COORD_W], COORD_W'(CAM_Z));
    sx = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    sy = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    sz = {{COORD_W{1'b0}}, dz} * {{COORD_W{1'b0}}, dz};
    return DW'(sx) + DW'(sy) + DW'(sz);
  endfunction

  function automatic logic [COLOR_W-1:0] sat_add(input logic [COLOR_W-1:0] a, input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COLOR_W] ? {COLOR_W{1'b1}} : s[COLOR_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [SW-1:0]      sidx_q, sidx_d;
  logic [LW-1:0]      lidx_q, lidx_d;
  logic [DW-1:0]      best_q, best_d;
  logic               hit_q, hit_d;
  logic [PW-1:0]      hitpt_q, hitpt_d;
  logic [COLOR_W-1:0] acc_q, acc_d;
  logic [COLOR_W-1:0] pix_q, pix_d;
  logic               col_q, col_d;
  logic [PW-1:0]      pnear_q, pnear_d;

  logic [EW-1:0]      sph_q  [NUM_SPHERES];
  logic [PW-1:0]      lpos_q [NUM_LIGHTS];
  logic [COLOR_W-1:0] lint_q [NUM_LIGHTS];

  logic [EW-1:0]      cur_sph;
  logic [COORD_W-1:0] cur_r;
  logic [COLOR_W-1:0] cur_int;
  logic               last_s, last_l, closer, shadow;
  logic               prim_end, prim_hit, light_end, light_add, rsi_req;
  logic [COLOR_W-1:0] acc_new;

  assign cur_sph = sph_q[sidx_q];
  assign cur_r   = cur_sph[3*COORD_W +: COORD_W];
  assign cur_int = lint_q[lidx_q];
  assign last_s  = (sidx_q == SW'(NUM_SPHERES - 1));
  assign last_l  = (lidx_q == LW'(NUM_LIGHTS - 1));
  // Strict compare: an equal-distance hit on a later sphere keeps the earlier one.
  assign closer  = col_q && (dist_sq(pnear_q) < best_q);
  assign shadow  = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_NEXT);

  assign bus.PIX_READY    = (state_q == IDLE);
  assign bus.BUSY         = (state_q != IDLE);
  assign bus.OUT_VALID    = (state_q == OUT);
  assign bus.OUTPUT_PIXEL = pix_q;
  assign bus.RSI_REQ      = rsi_req;
  assign bus.RSI_SPHERE   = cur_sph;
  assign bus.RSI_P0       = shadow ? hitpt_q
                                   : {COORD_W'(CAM_Z), COORD_W'(CAM_Y), COORD_W'(CAM_X)};
  assign bus.RSI_P1       = shadow ? lpos_q[lidx_q] : {COORD_W'(FOCAL), y_q, x_q};
  assign bus.RSI_BOUNDED  = shadow;
  assign bus.RSI_THRESH   = shadow ? 4'(SHADOW_THR) : 4'd0;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    sidx_d    = sidx_q;
    lidx_d    = lidx_q;
    best_d    = best_q;
    hit_d     = hit_q;
    hitpt_d   = hitpt_q;
    acc_d     = acc_q;
    pix_d     = pix_q;
    col_d     = col_q;
    pnear_d   = pnear_q;
    prim_end  = 1'b0;
    prim_hit  = 1'b0;
    light_end = 1'b0;
    light_add = 1'b0;
    rsi_req   = 1'b0;
    acc_new   = acc_q;
    case (state_q)
      IDLE: if (bus.PIX_VALID) begin
        x_d     = COORD_W'(bus.X_in);
        y_d     = COORD_W'(bus.Y_in);
        sidx_d  = '0;
        best_d  = '1;
        hit_d   = 1'b0;
        state_d = P_ISSUE;
      end
      P_ISSUE: begin
        // Empty slots are skipped without bothering the RSI unit.
        if (cur_r == '0) begin
          if (last_s) begin
            prim_end = 1'b1;
            prim_hit = hit_q;
          end else begin
            sidx_d = sidx_q + SW'(1);
          end
        end else begin
          rsi_req = 1'b1;
          state_d = P_WAIT;
        end
      end
      P_WAIT: if (bus.RSI_DONE) begin
        col_d   = bus.RSI_COLLIDE;
        pnear_d = bus.RSI_PNEAR;
        state_d = P_NEXT;
      end
      P_NEXT: begin
        if (closer) begin
          best_d  = dist_sq(pnear_q);
          hitpt_d = pnear_q;
          hit_d   = 1'b1;
        end
        if (last_s) begin
          prim_end = 1'b1;
          prim_hit = hit_q | closer;
        end else begin
          sidx_d  = sidx_q + SW'(1);
          state_d = P_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cur_int == '0) begin
          light_end = 1'b1;
        end else if (cur_r == '0) begin
          if (last_s) begin
            light_end = 1'b1;
            light_add = 1'b1;
          end else begin
            sidx_d = sidx_q + SW'(1);
          end
        end else begin
          rsi_req = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (bus.RSI_DONE) begin
        col_d   = bus.RSI_COLLIDE;
        pnear_d = bus.RSI_PNEAR;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        // First blocker settles the light; its remaining spheres are not tested.
        if (col_q) begin
          light_end = 1'b1;
        end else if (last_s) begin
          light_end = 1'b1;
          light_add = 1'b1;
        end else begin
          sidx_d  = sidx_q + SW'(1);
          state_d = S_ISSUE;
        end
      end
      OUT: if (bus.OUT_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (prim_end) begin
      if (prim_hit) begin
        lidx_d  = '0;
        sidx_d  = '0;
        acc_d   = COLOR_W'(AMB_C);
        state_d = S_ISSUE;
      end else begin
        pix_d   = '0;
        state_d = OUT;
      end
    end

    if (light_end) begin
      if (light_add) acc_new = sat_add(acc_q, cur_int);
      acc_d = acc_new;
      if (last_l) begin
        pix_d   = acc_new;
        state_d = OUT;
      end else begin
        lidx_d  = lidx_q + LW'(1);
        sidx_d  = '0;
        state_d = S_ISSUE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  always_ff @(posedge CLK) begin
    x_q     <= x_d;
    y_q     <= y_d;
    sidx_q  <= sidx_d;
    lidx_q  <= lidx_d;
    best_q  <= best_d;
    hit_q   <= hit_d;
    hitpt_q <= hitpt_d;
    acc_q   <= acc_d;
    col_q   <= col_d;
    pnear_q <= pnear_d;
  end

  // Scene store: only writable while idle so a pixel sees a consistent scene.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SPHERES; i++) sph_q[i] <= '0;
      for (int j = 0; j < NUM_LIGHTS; j++) lint_q[j] <= '0;
    end else begin
      if (bus.SCENE_WE && (state_q == IDLE)) begin
        if (!bus.SCENE_SEL && (int'(bus.SCENE_IDX) < NUM_SPHERES)) begin
          sph_q[bus.SCENE_IDX[SW-1:0]] <= bus.SCENE_DATA;
        end
        if (bus.SCENE_SEL && (int'(bus.SCENE_IDX) < NUM_LIGHTS)) begin
          lpos_q[bus.SCENE_IDX[LW-1:0]] <= bus.SCENE_DATA[PW-1:0];
          lint_q[bus.SCENE_IDX[LW-1:0]] <= bus.SCENE_DATA[3*COORD_W +: COLOR_W];
        end
      end
`ifdef RT_ANIM_EN
      if ((state_q == IDLE) && bus.PIX_VALID && (bus.X_in == '0) && (bus.Y_in == '0)) begin
        sph_q[0][0 +: COORD_W] <= (sph_q[0][0 +: COORD_W] < COORD_W'(540))
                                  ? sph_q[0][0 +: COORD_W] + COORD_W'(1)
                                  : COORD_W'(100);
      end
`else
`endif
    end
  end
endmodule
